// File: rtl/regfile_wb_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared types and constants for the regfile writeback scheduler.
//            Register-address width and count, the address typedef, a packed
//            writeback-request record and a small x0 helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int WB_XLEN    = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t            rd;
    logic [WB_XLEN-1:0]   data;
  } wb_req_t;

  // x0 is hardwired to zero: writes to it are swallowed, it is never busy.
  function automatic logic is_x0(input reg_addr_t addr);
    return (addr == '0);
  endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_wb_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_scheduler_if
// Purpose  : Writeback-request bus between NUM_REQ requesters and the
//            scheduler. Requester k owns bit k of req_valid_i/req_ready_o,
//            bits [5k+4:5k] of req_rd_i and slice k of req_data_i.
// Modports : master - requester side (drives valid/rd/data, sees ready)
//            slave  - scheduler side (sees valid/rd/data, drives ready)
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_scheduler_if
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
);

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd_i;
  logic [NUM_REQ*XLEN-1:0]       req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;

  modport master (
    output req_valid_i,
    output req_rd_i,
    output req_data_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_rd_i,
    input  req_data_i,
    output req_ready_o
  );

endinterface : regfile_wb_scheduler_if
`default_nettype wire

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. Searches req starting at
//            index ptr and wrapping, grants the first asserted request.
// Ports    : req     in  N      request vector
//            ptr     in  PTR_W  index searched first
//            gnt     out N      one-hot grant (all zero when no request)
//            gnt_idx out PTR_W  index of the granted request
//            gnt_any out 1      any request granted
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             gnt_any
);

  // One extra bit so ptr + offset (at most 2N-2) never overflows before wrap.
  logic [PTR_W:0] pos;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    pos     = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(i);
      if (pos >= (PTR_W+1)'(N)) begin
        pos = pos - (PTR_W+1)'(N);
      end
      if (!gnt_any && req[pos[PTR_W-1:0]]) begin
        gnt[pos[PTR_W-1:0]] = 1'b1;
        gnt_idx             = pos[PTR_W-1:0];
        gnt_any             = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_scheduler
// Purpose  : Shares the single regfile write port among NUM_REQ writeback
//            requesters (round-robin, valid/ready) and keeps a scoreboard of
//            destination registers with outstanding writes for decode.
// Ports    : clk, reset_n (async, active-low), flush_i (sync flush)
//            wb            - requester bus (regfile_wb_scheduler_if.slave)
//            rf_wr_en_o / rf_rd_addr_o / rf_wr_data_o - registered write port
//            rsv_valid_i / rsv_rd_i / rsv_ready_o      - decode reservation
//            rs1/rs2_addr_i -> rs1/rs2_busy_o           - hazard query
// Option   : REGFILE_WB_BYPASS_EN adds rs1/rs2_rf_data_i and rs1/rs2_data_o;
//            an in-flight write to a queried source is forwarded and that
//            source is reported not busy.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush_i,
  regfile_wb_scheduler_if.slave  wb,
  output logic                   rf_wr_en_o,
  output reg_addr_t              rf_rd_addr_o,
  output logic [XLEN-1:0]        rf_wr_data_o,
  input  logic                   rsv_valid_i,
  input  reg_addr_t              rsv_rd_i,
  output logic                   rsv_ready_o,
  input  reg_addr_t              rs1_addr_i,
  input  reg_addr_t              rs2_addr_i,
  output logic                   rs1_busy_o,
  output logic                   rs2_busy_o
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [XLEN-1:0]        rs1_rf_data_i,
  input  logic [XLEN-1:0]        rs2_rf_data_i,
  output logic [XLEN-1:0]        rs1_data_o,
  output logic [XLEN-1:0]        rs2_data_o
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0]  gnt;
  logic [PTR_W-1:0]    gnt_idx;
  logic                gnt_any;
  reg_addr_t           sel_rd;
  logic [XLEN-1:0]     sel_data;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                rsv_fire;
  logic [PTR_W-1:0]    ptr_nxt;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req     (wb.req_valid_i),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign wb.req_ready_o = gnt;

  assign sel_rd   = wb.req_rd_i[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign sel_data = wb.req_data_i[int'(gnt_idx)*XLEN +: XLEN];

  assign ptr_nxt = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  assign rsv_ready_o = !busy[rsv_rd_i];
  assign rsv_fire    = rsv_valid_i && rsv_ready_o;

  // Clear for the committing write is applied first so a same-edge
  // reservation of the same register ends up set.
  always_comb begin
    busy_nxt = busy;
    if (rf_wr_en_o) begin
      busy_nxt[rf_rd_addr_o] = 1'b0;
    end
    if (rsv_fire && !is_x0(rsv_rd_i)) begin
      busy_nxt[rsv_rd_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
    if (flush_i) begin
      busy_nxt = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Registered write port, pointer and scoreboard state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_wr_en_o   <= 1'b0;
      rf_rd_addr_o <= '0;
      rf_wr_data_o <= '0;
      rr_ptr       <= '0;
      busy         <= '0;
    end else begin
      busy <= busy_nxt;
      if (flush_i) begin
        // The handshake on a flush edge still completes for the requester,
        // but its write is dropped and the pointer does not advance.
        rf_wr_en_o <= 1'b0;
      end else if (gnt_any) begin
        rf_wr_en_o   <= !is_x0(sel_rd);
        rf_rd_addr_o <= sel_rd;
        rf_wr_data_o <= sel_data;
        rr_ptr       <= ptr_nxt;
      end else begin
        rf_wr_en_o <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Source hazard query (and optional forwarding)
  // --------------------------------------------------------------------------
`ifdef REGFILE_WB_BYPASS_EN
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = rf_wr_en_o && (rf_rd_addr_o == rs1_addr_i) && !is_x0(rs1_addr_i);
  assign rs2_hit = rf_wr_en_o && (rf_rd_addr_o == rs2_addr_i) && !is_x0(rs2_addr_i);

  assign rs1_data_o = rs1_hit ? rf_wr_data_o : rs1_rf_data_i;
  assign rs2_data_o = rs2_hit ? rf_wr_data_o : rs2_rf_data_i;
  assign rs1_busy_o = busy[rs1_addr_i] && !rs1_hit;
  assign rs2_busy_o = busy[rs2_addr_i] && !rs2_hit;
`else
  assign rs1_busy_o = busy[rs1_addr_i];
  assign rs2_busy_o = busy[rs2_addr_i];
`endif

endmodule : regfile_wb_scheduler
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_scheduler
// Purpose  : Self-checking bench for regfile_wb_scheduler: directed vector
//            table, hand-written round-robin / flush / reset / bypass
//            sequences, and a randomized run against a behavioural model.
// Option   : REGFILE_WB_BYPASS_EN selects the forwarding checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  localparam int N  = 3;
  localparam int XL = 32;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam bit NB = !BYP;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        rf_wr_en;
  reg_addr_t   rf_addr;
  logic [31:0] rf_data;
  logic        rsv_valid = 1'b0;
  reg_addr_t   rsv_rd = '0;
  logic        rsv_ready;
  reg_addr_t   rs1 = '0;
  reg_addr_t   rs2 = '0;
  logic        rs1_busy;
  logic        rs2_busy;
`ifdef REGFILE_WB_BYPASS_EN
  logic [31:0] rs1_rf_data = '0;
  logic [31:0] rs2_rf_data = '0;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
`endif

  regfile_wb_scheduler_if #(.NUM_REQ(N), .XLEN(XL)) wb_bus ();

  regfile_wb_scheduler #(.NUM_REQ(N), .XLEN(XL)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush_i       (flush),
    .wb            (wb_bus),
    .rf_wr_en_o    (rf_wr_en),
    .rf_rd_addr_o  (rf_addr),
    .rf_wr_data_o  (rf_data),
    .rsv_valid_i   (rsv_valid),
    .rsv_rd_i      (rsv_rd),
    .rsv_ready_o   (rsv_ready),
    .rs1_addr_i    (rs1),
    .rs2_addr_i    (rs2),
    .rs1_busy_o    (rs1_busy),
    .rs2_busy_o    (rs2_busy)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .rs1_rf_data_i (rs1_rf_data),
    .rs2_rf_data_i (rs2_rf_data),
    .rs1_data_o    (rs1_data),
    .rs2_data_o    (rs2_data)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requester-side shadow of the bus so each requester is driven independently.
  logic [2:0]  v   = '0;
  reg_addr_t   rdq [N];
  logic [31:0] dq  [N];

  task automatic drive_bus();
    for (int k = 0; k < N; k++) begin
      wb_bus.req_valid_i[k]         = v[k];
      wb_bus.req_rd_i[5*k +: 5]     = rdq[k];
      wb_bus.req_data_i[32*k +: 32] = dq[k];
    end
  endtask

  task automatic idle_inputs();
    v = '0;
    for (int k = 0; k < N; k++) begin
      rdq[k] = '0;
      dq[k]  = '0;
    end
    drive_bus();
    flush     = 1'b0;
    rsv_valid = 1'b0;
    rsv_rd    = '0;
    rs1       = '0;
    rs2       = '0;
  endtask

  // Called at posedge+1; leaves time at posedge+3, before the next negedge.
  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    #2;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  valid;
    reg_addr_t   rd0, rd1, rd2;
    logic [31:0] d0, d1, d2;
    logic        rsv_v;
    reg_addr_t   rsv_rd, rs1, rs2;
    logic [2:0]  e_ready;
    logic        e_rsv_ready, e_rs1_busy, e_rs2_busy;
    logic        e_wr_en;
    logic        chk_bus;
    reg_addr_t   e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs [9];

  // Behavioural model for the random phase.
  bit          mbusy [32];
  int          mptr;
  bit          mwr;
  reg_addr_t   maddr;
  logic [31:0] mdata;

  initial begin
    int g;
    logic all_clear;
    logic [2:0] exp_rdy;

    idle_inputs();

    // ---------------- reset state ----------------
    #12;
    chk("reset_wr_en", 64'(rf_wr_en), 64'd0);
    chk("reset_addr",  64'(rf_addr),  64'd0);
    chk("reset_data",  64'(rf_data),  64'd0);
    chk("reset_ready", 64'(wb_bus.req_ready_o), 64'd0);
    all_clear = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rs1 = reg_addr_t'(a);
      #0.1;
      if (rs1_busy !== 1'b0) all_clear = 1'b0;
    end
    rs1 = '0;
    chk("reset_scoreboard_clear", 64'(all_clear), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // ---------------- directed vector table ----------------
    vecs[0] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0};
    vecs[1] = '{3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 5'd5, 5'd5, 5'd0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[2] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd5, 5'd5, 5'd0, 3'b000, 1'b0, NB, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[3] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd5, 5'd7, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[4] = '{3'b111, 5'd7, 5'd3, 5'd0, 32'h70, 32'h31, 32'h1234, 1'b1, 5'd7, 5'd7, 5'd0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h31};
    vecs[5] = '{3'b101, 5'd7, 5'd3, 5'd0, 32'h70, 32'h31, 32'h1234, 1'b1, 5'd0, 5'd7, 5'd0, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    vecs[6] = '{3'b001, 5'd7, 5'd3, 5'd0, 32'h70, 32'h31, 32'h1234, 1'b0, 5'd0, 5'd7, 5'd0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h70};
    vecs[7] = '{3'b000, 5'd7, 5'd3, 5'd0, 32'h70, 32'h31, 32'h1234, 1'b0, 5'd7, 5'd7, 5'd0, 3'b000, 1'b0, NB, 1'b0, 1'b0, 1'b1, 5'd7, 32'h70};
    vecs[8] = '{3'b000, 5'd7, 5'd3, 5'd0, 32'h70, 32'h31, 32'h1234, 1'b0, 5'd7, 5'd7, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h70};

    for (int i = 0; i < 9; i++) begin
      v = vecs[i].valid;
      rdq[0] = vecs[i].rd0; rdq[1] = vecs[i].rd1; rdq[2] = vecs[i].rd2;
      dq[0]  = vecs[i].d0;  dq[1]  = vecs[i].d1;  dq[2]  = vecs[i].d2;
      drive_bus();
      rsv_valid = vecs[i].rsv_v;
      rsv_rd    = vecs[i].rsv_rd;
      rs1       = vecs[i].rs1;
      rs2       = vecs[i].rs2;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i),     64'(wb_bus.req_ready_o), 64'(vecs[i].e_ready));
      chk($sformatf("vec%0d_rsv_ready", i), 64'(rsv_ready), 64'(vecs[i].e_rsv_ready));
      chk($sformatf("vec%0d_rs1_busy", i),  64'(rs1_busy),  64'(vecs[i].e_rs1_busy));
      chk($sformatf("vec%0d_rs2_busy", i),  64'(rs2_busy),  64'(vecs[i].e_rs2_busy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_wr_en", i), 64'(rf_wr_en), 64'(vecs[i].e_wr_en));
      if (vecs[i].chk_bus) begin
        chk($sformatf("vec%0d_addr", i), 64'(rf_addr), 64'(vecs[i].e_addr));
        chk($sformatf("vec%0d_data", i), 64'(rf_data), 64'(vecs[i].e_data));
      end
    end

    // ---------------- round-robin with all requesters held valid ----------------
    do_reset();
    for (int k = 0; k < N; k++) begin
      rdq[k] = reg_addr_t'(10 + k);
      dq[k]  = 32'h100 + 32'(k);
    end
    v = 3'b111;
    drive_bus();
    for (int c = 0; c < 6; c++) begin
      int e;
      e = c % 3;
      @(negedge clk);
      chk($sformatf("rr%0d_ready", c), 64'(wb_bus.req_ready_o), 64'(3'b001 << e));
      @(posedge clk); #1;
      chk($sformatf("rr%0d_wr_en", c), 64'(rf_wr_en), 64'd1);
      chk($sformatf("rr%0d_addr", c),  64'(rf_addr),  64'(10 + e));
      chk($sformatf("rr%0d_data", c),  64'(rf_data),  64'(dq[e]));
      dq[e] = dq[e] + 32'h10;
      drive_bus();
    end

    // ---------------- flush with a write in flight, then async reset ----------------
    do_reset();
    rsv_valid = 1'b1; rsv_rd = 5'd3;
    @(posedge clk); #1;
    rsv_rd = 5'd9;
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    v = 3'b001; rdq[0] = 5'd3; dq[0] = 32'h33;
    drive_bus();
    @(posedge clk); #1;
    chk("flush_pre_wr_en", 64'(rf_wr_en), 64'd1);
    chk("flush_pre_addr",  64'(rf_addr),  64'd3);
    v = 3'b010; rdq[1] = 5'd9; dq[1] = 32'h99;
    drive_bus();
    flush = 1'b1;
    rs1 = 5'd3; rs2 = 5'd9;
    @(negedge clk);
    chk("flush_pre_rs2_busy", 64'(rs2_busy), 64'd1);
    chk("flush_ready_r1",     64'(wb_bus.req_ready_o), 64'd2);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_wr_en",    64'(rf_wr_en), 64'd0);
    chk("flush_rs1_busy", 64'(rs1_busy), 64'd0);
    chk("flush_rs2_busy", 64'(rs2_busy), 64'd0);
    // Pointer held at 1 through the flush.
    v = 3'b111;
    rdq[0] = 5'd1; rdq[1] = 5'd2; rdq[2] = 5'd4;
    drive_bus();
    @(negedge clk);
    chk("flush_ptr_hold", 64'(wb_bus.req_ready_o), 64'd2);
    @(posedge clk); #1;
    chk("post_flush_addr", 64'(rf_addr), 64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_wr_en", 64'(rf_wr_en), 64'd0);
    chk("async_rst_addr",  64'(rf_addr),  64'd0);
    chk("async_rst_data",  64'(rf_data),  64'd0);
    idle_inputs();
    @(posedge clk); #1;
    reset_n = 1'b1;

`ifdef REGFILE_WB_BYPASS_EN
    // ---------------- forwarding of an in-flight write ----------------
    rsv_valid = 1'b1; rsv_rd = 5'd12;
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    v = 3'b001; rdq[0] = 5'd12; dq[0] = 32'hA5A5A5A5;
    drive_bus();
    @(posedge clk); #1;
    v = 3'b000;
    drive_bus();
    rs1 = 5'd12; rs2 = 5'd13;
    rs1_rf_data = 32'h11111111; rs2_rf_data = 32'h22222222;
    #1;
    chk("byp_rs1_data", 64'(rs1_data), 64'hA5A5A5A5);
    chk("byp_rs1_busy", 64'(rs1_busy), 64'd0);
    chk("byp_rs2_data", 64'(rs2_data), 64'h22222222);
    @(posedge clk); #1;
    chk("byp_after_rs1_data", 64'(rs1_data), 64'h11111111);
    idle_inputs();
`endif

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int a = 0; a < 32; a++) mbusy[a] = 1'b0;
    mptr = 0; mwr = 1'b0; maddr = '0; mdata = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic exp_rsv_rdy, exp_b1, exp_b2;
      for (int k = 0; k < N; k++) begin
        if (!v[k] && ($urandom_range(1, 0) == 1)) begin
          v[k]   = 1'b1;
          rdq[k] = reg_addr_t'($urandom_range(7, 0));
          dq[k]  = $urandom;
        end
      end
      drive_bus();
      flush     = ($urandom_range(39, 0) == 0);
      rsv_rd    = reg_addr_t'($urandom_range(7, 0));
      rsv_valid = ($urandom_range(1, 0) == 1);
      if (mwr && rsv_rd == maddr) rsv_valid = 1'b0;
      rs1 = reg_addr_t'($urandom_range(7, 0));
      rs2 = reg_addr_t'($urandom_range(7, 0));
`ifdef REGFILE_WB_BYPASS_EN
      rs1_rf_data = $urandom;
      rs2_rf_data = $urandom;
`endif
      g = -1;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (mptr + i) % N;
        if (g < 0 && v[k]) g = k;
      end
      exp_rdy     = (g < 0) ? 3'b000 : (3'b001 << g);
      exp_rsv_rdy = !mbusy[rsv_rd];
      exp_b1 = mbusy[rs1] && !(BYP && mwr && maddr == rs1 && rs1 != 0);
      exp_b2 = mbusy[rs2] && !(BYP && mwr && maddr == rs2 && rs2 != 0);
      @(negedge clk);
      chk("rnd_ready",     64'(wb_bus.req_ready_o), 64'(exp_rdy));
      chk("rnd_rsv_ready", 64'(rsv_ready), 64'(exp_rsv_rdy));
      chk("rnd_rs1_busy",  64'(rs1_busy),  64'(exp_b1));
      chk("rnd_rs2_busy",  64'(rs2_busy),  64'(exp_b2));
      chk("rnd_no_set_clear_overlap",
          64'(rsv_valid && rsv_ready && rf_wr_en && (rf_addr == rsv_rd)), 64'd0);
`ifdef REGFILE_WB_BYPASS_EN
      chk("rnd_rs1_data", 64'(rs1_data),
          64'((mwr && maddr == rs1 && rs1 != 0) ? mdata : rs1_rf_data));
      chk("rnd_rs2_data", 64'(rs2_data),
          64'((mwr && maddr == rs2 && rs2 != 0) ? mdata : rs2_rf_data));
`endif
      // Model update for this edge.
      if (flush) begin
        for (int a = 0; a < 32; a++) mbusy[a] = 1'b0;
        mwr = 1'b0;
      end else begin
        if (mwr) mbusy[maddr] = 1'b0;
        if (rsv_valid && exp_rsv_rdy && rsv_rd != 0) mbusy[rsv_rd] = 1'b1;
        if (g >= 0) begin
          mwr   = (rdq[g] != 0);
          maddr = rdq[g];
          mdata = dq[g];
          mptr  = (g + 1) % N;
        end else begin
          mwr = 1'b0;
        end
      end
      if (g >= 0) v[g] = 1'b0;
      @(posedge clk); #1;
      chk("rnd_wr_en", 64'(rf_wr_en), 64'(mwr));
      if (mwr) begin
        chk("rnd_addr", 64'(rf_addr), 64'(maddr));
        chk("rnd_data", 64'(rf_data), 64'(mdata));
      end
    end

    idle_inputs();
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_regfile_wb_scheduler
`default_nettype wire
